pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Sequencing controller for the 5-stage pipelined MIPS datapath. It generates per-latch enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB from cache hits, RAW hazards, control-flow redirects resolved in MEM, and halt. It also drives the data-memory request lines, replacing `request_unit`, and maintains cycle/stall performance counters. The block is instantiated in `datapath` beside the four pipeline latches.

## Interface
Parameters:
- `CNT_W`, 32: width of performance counters.

Ports:
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  instruction fetch completed this cycle.
- `dhit`  in  1  data access completed this cycle.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in IF/ID.
- `id_uses_rt`  in  1  ID instruction reads `rt` as a source.
- `ex_regwrite`, `ex_wsel`  in  1/5  ID/EX destination write-enable and register.
- `mem_regwrite`, `mem_wsel`  in  1/5  EX/MEM destination write-enable and register.
- `mem_ren`, `mem_wen`  in  1 each  EX/MEM load/store request.
- `mem_pctaken`  in  1  EX/MEM branch taken or jump; `npc_mux` is selecting a non-sequential PC.
- `mem_halt`  in  1  EX/MEM holds HALT.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  latch load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`  out  1 each  latch loads a NOP (all controls 0). Flush overrides the enable.
- `dmemREN`, `dmemWEN`  out  1 each  data-cache request.
- `halt`  out  1  processor halted (sticky).
- `cycle_count`, `stall_count`  out  `CNT_W` each  performance counters.

## Operation
- FSM in `ctrl_state_t`: RUN and HALT. Reset enters RUN.
- Combinational terms, all gated by RUN:
  - `mem_acc = mem_ren | mem_wen`
  - `back_adv = mem_acc ? dhit : ihit`
  - `raw = (id_rs != 0 & ((ex_regwrite & ex_wsel == id_rs) | (mem_regwrite & mem_wsel == id_rs)))`, OR the same check on `id_rt` qualified by `id_uses_rt`. Register 0 never causes a hazard.
- Priority, highest first:
  1. Redirect (`back_adv & mem_pctaken`): `pc_en`=1; flush IF/ID, ID/EX and EX/MEM; `memwb_en`=1.
  2. Backend-only (`back_adv & mem_acc & ~ihit`): `exmem_flush`=1, `memwb_en`=1; PC, IF/ID and ID/EX hold.
  3. RAW (`back_adv & raw`): PC and IF/ID hold; `idex_flush`=1; `exmem_en`=1, `memwb_en`=1.
  4. Normal (`back_adv`): all enables 1, no flush.
  5. Otherwise all enables 0 and all flushes 0.
- Data memory: `dmemREN = RUN & mem_ren`, `dmemWEN = RUN & mem_wen`. Each stays high until `dhit`; EX/MEM holds the request steady meanwhile.
- Halt: on an edge where RUN & `mem_halt` & `back_adv`, go to HALT. The older instruction in MEM/WB writes back on that same edge. HALT exits only by reset.
- In HALT: `halt`=1; all enables, flushes and dmem requests are 0.
- WB-to-ID hazards are not detected here. `register_file` must provide write-through.
- Counters:
  - `cycle_count` increments every RUN cycle.
  - `stall_count` increments every RUN cycle with `pc_en`=0.
  - Both wrap modulo 2^CNT_W and freeze in HALT.

## Timing
- Controls are combinational from the current cycle's inputs. There is no added latency, and every decision takes effect on the next rising edge.
- Reset values: state RUN, `halt`=0, counters 0. Other outputs follow inputs immediately after reset.
- Asserting reset mid-access drops `dmemREN`/`dmemWEN` asynchronously and clears state and counters.
- Load-use costs one bubble per cycle while the load sits in EX or MEM, i.e. 2 stall cycles total without forwarding.
- A redirect costs 3 flushed slots.
- `dhit` and `ihit` in the same cycle with a memory access behave as Normal.
- `mem_pctaken` with `back_adv`=0: nothing moves, and the redirect retries next cycle.

## Structure
- In `cpu_types_pkg`: `ctrl_state_t` enum {RUN, HALT}.
- Sub-module `hazard_detect` (combinational): takes the ID sources and the EX/MEM destinations, and outputs `raw`.
- The FSM, priority logic and counters live in `pipeline_controller`.

## Test plan
- Reset with `ihit`=1 and no hazards → all enables 1; `halt`=0; after 10 cycles `cycle_count`=10 and `stall_count`=0.
- `id_rs`=5, `ex_regwrite`=1, `ex_wsel`=5, `ihit`=1 → `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `exmem_en`=1. The same check with `id_rs`=0 → no stall.
- `mem_ren`=1 with `dhit` low for 3 cycles → `dmemREN`=1 and all enables 0 for those cycles. `dhit`=1, `ihit`=0 → `memwb_en`=1, `exmem_flush`=1, `pc_en`=0.
- `mem_pctaken`=1, `ihit`=1 → `pc_en`=1; `ifid_flush`, `idex_flush` and `exmem_flush` all 1.
- `mem_halt`=1, `ihit`=1 → after the edge `halt`=1 and all enables 0. Counters stay frozen for 5 cycles; `halt` remains 1 until `nRST`.
- `nRST` pulsed low while `dmemWEN`=1 → `dmemWEN` drops immediately; counters read 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and helpers for the pipeline sequencing controller.
package cpu_types_pkg;

    // Controller state: RUN sequences the pipeline, HALT freezes it until reset.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } ctrl_state_t;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Per-latch load enables and NOP-insert flushes driven toward the datapath.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } latch_ctrl_t;

    localparam latch_ctrl_t CTRL_IDLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // True when a pending write targets the given source; register 0 is never a hazard.
    function automatic logic dest_match(
        input logic             we,
        input logic [REG_W-1:0] wsel,
        input logic [REG_W-1:0] src
    );
        return we && (wsel == src) && (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// RAW hazard detection between the instruction in ID and older writers in EX and MEM.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic             [REG_W-1:0] id_rs,
    input  logic             [REG_W-1:0] id_rt,
    input  logic                         id_uses_rt,
    input  logic                         ex_regwrite,
    input  logic             [REG_W-1:0] ex_wsel,
    input  logic                         mem_regwrite,
    input  logic             [REG_W-1:0] mem_wsel,
    output logic                         raw
);

    logic rs_hit_s;
    logic rt_hit_s;

    // Compare both sources against the EX and MEM destinations; rt only counts when read.
    always_comb begin
        rs_hit_s = dest_match(ex_regwrite, ex_wsel, id_rs)
                 | dest_match(mem_regwrite, mem_wsel, id_rs);
        rt_hit_s = id_uses_rt
                 & (dest_match(ex_regwrite, ex_wsel, id_rt)
                  | dest_match(mem_regwrite, mem_wsel, id_rt));
        raw      = rs_hit_s | rt_hit_s;
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencing controller: latch enables/flushes, data-memory requests,
// sticky halt and cycle/stall performance counters.
module pipeline_controller
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_regwrite,
    input  logic [REG_W-1:0]  ex_wsel,
    input  logic              mem_regwrite,
    input  logic [REG_W-1:0]  mem_wsel,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic              mem_pctaken,
    input  logic              mem_halt,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              halt,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_t state_r;
    ctrl_state_t next_state_s;
    latch_ctrl_t ctrl_s;
    logic        raw_s;
    logic        run_s;
    logic        mem_acc_s;
    logic        back_adv_s;
    logic [CNT_W-1:0] cycle_count_r;
    logic [CNT_W-1:0] stall_count_r;

    hazard_detect u_hazard_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_regwrite  (ex_regwrite),
        .ex_wsel      (ex_wsel),
        .mem_regwrite (mem_regwrite),
        .mem_wsel     (mem_wsel),
        .raw          (raw_s)
    );

    // Advance condition: a memory access in MEM waits on dhit, otherwise on ihit.
    always_comb begin
        run_s      = (state_r == RUN);
        mem_acc_s  = mem_ren | mem_wen;
        back_adv_s = run_s & (mem_acc_s ? dhit : ihit);
    end

    // State register: reset enters RUN.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: HALT is entered when the HALT in MEM advances, and is left only by reset.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RUN: begin
                if (mem_halt && back_adv_s) begin
                    next_state_s = HALT;
                end else begin
                    next_state_s = RUN;
                end
            end
            HALT:    next_state_s = HALT;
            default: next_state_s = RUN;
        endcase
    end

    // Output decode: prioritised latch controls; flushed latches keep their enable low.
    always_comb begin
        ctrl_s = CTRL_IDLE;
        case (state_r)
            RUN: begin
                if (back_adv_s && mem_pctaken) begin
                    ctrl_s.pc_en       = 1'b1;
                    ctrl_s.ifid_flush  = 1'b1;
                    ctrl_s.idex_flush  = 1'b1;
                    ctrl_s.exmem_flush = 1'b1;
                    ctrl_s.memwb_en    = 1'b1;
                end else if (back_adv_s && mem_acc_s && !ihit) begin
                    ctrl_s.exmem_flush = 1'b1;
                    ctrl_s.memwb_en    = 1'b1;
                end else if (back_adv_s && raw_s) begin
                    ctrl_s.idex_flush  = 1'b1;
                    ctrl_s.exmem_en    = 1'b1;
                    ctrl_s.memwb_en    = 1'b1;
                end else if (back_adv_s) begin
                    ctrl_s.pc_en       = 1'b1;
                    ctrl_s.ifid_en     = 1'b1;
                    ctrl_s.idex_en     = 1'b1;
                    ctrl_s.exmem_en    = 1'b1;
                    ctrl_s.memwb_en    = 1'b1;
                end else begin
                    ctrl_s = CTRL_IDLE;
                end
            end
            HALT:    ctrl_s = CTRL_IDLE;
            default: ctrl_s = CTRL_IDLE;
        endcase
    end

    // Drive latch controls and data-memory requests; requests also drop while reset is held.
    always_comb begin
        pc_en       = ctrl_s.pc_en;
        ifid_en     = ctrl_s.ifid_en;
        idex_en     = ctrl_s.idex_en;
        exmem_en    = ctrl_s.exmem_en;
        memwb_en    = ctrl_s.memwb_en;
        ifid_flush  = ctrl_s.ifid_flush;
        idex_flush  = ctrl_s.idex_flush;
        exmem_flush = ctrl_s.exmem_flush;
        dmemREN     = nRST & run_s & mem_ren;
        dmemWEN     = nRST & run_s & mem_wen;
        halt        = (state_r == HALT);
    end

    // Performance counters: count RUN cycles and RUN cycles with the PC held; frozen in HALT.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cycle_count_r <= '0;
            stall_count_r <= '0;
        end else if (run_s) begin
            cycle_count_r <= cycle_count_r + CNT_ONE;
            if (!ctrl_s.pc_en) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end else begin
            cycle_count_r <= cycle_count_r;
            stall_count_r <= stall_count_r;
        end
    end

    assign cycle_count = cycle_count_r;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller.
module tb_pipeline_controller;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rt;
    logic        ex_regwrite;
    logic [4:0]  ex_wsel;
    logic        mem_regwrite;
    logic [4:0]  mem_wsel;
    logic        mem_ren, mem_wen, mem_pctaken, mem_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        dmemREN, dmemWEN, halt;
    logic [31:0] cycle_count, stall_count;

    int checks = 0;
    int errors = 0;
    int exp_cyc = 0;
    int exp_stl = 0;
    bit exp_halted = 1'b0;

    wire [4:0] en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    wire [2:0] fl = {ifid_flush, idex_flush, exmem_flush};

    pipeline_controller #(.CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_regwrite(ex_regwrite), .ex_wsel(ex_wsel),
        .mem_regwrite(mem_regwrite), .mem_wsel(mem_wsel),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_pctaken(mem_pctaken), .mem_halt(mem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt(halt),
        .cycle_count(cycle_count), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        ihit = 1'b0; dhit = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_regwrite = 1'b0; ex_wsel = 5'd0;
        mem_regwrite = 1'b0; mem_wsel = 5'd0;
        mem_ren = 1'b0; mem_wen = 1'b0; mem_pctaken = 1'b0; mem_halt = 1'b0;
    endtask

    // One clock edge; the expected counters advance only while the model is running.
    task automatic tick(input bit stalled);
        @(posedge CLK);
        #1;
        if (!exp_halted) begin
            exp_cyc++;
            if (stalled) exp_stl++;
        end
    endtask

    task automatic check_counters(input string tag);
        checks++;
        if (cycle_count !== 32'(exp_cyc) || stall_count !== 32'(exp_stl)) begin
            $display("FAIL %s: cycle=%0d stall=%0d expected cycle=%0d stall=%0d",
                     tag, cycle_count, stall_count, exp_cyc, exp_stl);
            errors++;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        ihit = 1'b1;
        nRST = 1'b0;
        #2;
        checks++;
        if (halt !== 1'b0 || cycle_count !== 32'd0 || stall_count !== 32'd0) begin
            $display("FAIL reset_state: halt=%b cyc=%0d stl=%0d expected 0 0 0", halt, cycle_count, stall_count);
            errors++;
        end
        nRST = 1'b1;
        #1;
        checks++;
        if (en !== 5'b11111 || fl !== 3'b000) begin
            $display("FAIL reset_normal: en=%b fl=%b expected 11111 000", en, fl);
            errors++;
        end
        for (int i = 0; i < 10; i++) tick(1'b0);
        checks++;
        if (cycle_count !== 32'd10 || stall_count !== 32'd0) begin
            $display("FAIL reset_count10: cyc=%0d stl=%0d expected 10 0", cycle_count, stall_count);
            errors++;
        end
    endtask

    task automatic test_raw();
        clear_inputs();
        ihit = 1'b1; id_rs = 5'd5; ex_regwrite = 1'b1; ex_wsel = 5'd5;
        #1;
        checks++;
        if ({pc_en, ifid_en, exmem_en, memwb_en, fl} !== 7'b0011_010) begin
            $display("FAIL raw_ex_rs: pc,ifid,exmem,memwb,flush=%b expected 0011010",
                     {pc_en, ifid_en, exmem_en, memwb_en, fl});
            errors++;
        end
        tick(1'b1);
        id_rs = 5'd0; ex_wsel = 5'd0;
        #1;
        checks++;
        if (en !== 5'b11111 || fl !== 3'b000) begin
            $display("FAIL raw_zero_reg: en=%b fl=%b expected 11111 000", en, fl);
            errors++;
        end
        tick(1'b0);
        clear_inputs();
        ihit = 1'b1; id_rt = 5'd9; mem_regwrite = 1'b1; mem_wsel = 5'd9;
        #1;
        checks++;
        if (pc_en !== 1'b1 || idex_flush !== 1'b0) begin
            $display("FAIL raw_rt_unused: pc_en=%b idex_flush=%b expected 1 0", pc_en, idex_flush);
            errors++;
        end
        id_uses_rt = 1'b1;
        #1;
        checks++;
        if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_flush !== 1'b1 || exmem_en !== 1'b1) begin
            $display("FAIL raw_mem_rt: pc=%b ifid=%b idex_flush=%b exmem=%b expected 0 0 1 1",
                     pc_en, ifid_en, idex_flush, exmem_en);
            errors++;
        end
        tick(1'b1);
        check_counters("raw_counters");
    endtask

    task automatic test_dmem_wait();
        clear_inputs();
        ihit = 1'b1; mem_ren = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (dmemREN !== 1'b1 || en !== 5'b00000 || fl !== 3'b000) begin
                $display("FAIL dmem_wait%0d: dmemREN=%b en=%b fl=%b expected 1 00000 000", i, dmemREN, en, fl);
                errors++;
            end
            tick(1'b1);
        end
        ihit = 1'b0; dhit = 1'b1;
        #1;
        checks++;
        if ({pc_en, ifid_en, idex_en, memwb_en, fl} !== 7'b0001_001) begin
            $display("FAIL dmem_backend: pc,ifid,idex,memwb,flush=%b expected 0001001",
                     {pc_en, ifid_en, idex_en, memwb_en, fl});
            errors++;
        end
        tick(1'b1);
        ihit = 1'b1;
        #1;
        checks++;
        if (en !== 5'b11111 || fl !== 3'b000) begin
            $display("FAIL dmem_both_hits: en=%b fl=%b expected 11111 000", en, fl);
            errors++;
        end
        tick(1'b0);
        dhit = 1'b0; mem_pctaken = 1'b1;
        #1;
        checks++;
        if (en !== 5'b00000 || fl !== 3'b000) begin
            $display("FAIL redirect_no_adv: en=%b fl=%b expected 00000 000", en, fl);
            errors++;
        end
        tick(1'b1);
        check_counters("dmem_counters");
    endtask

    task automatic test_redirect();
        clear_inputs();
        mem_pctaken = 1'b1; ihit = 1'b1;
        #1;
        checks++;
        if ({pc_en, memwb_en, fl} !== 5'b11111) begin
            $display("FAIL redirect: pc,memwb,flush=%b expected 11111", {pc_en, memwb_en, fl});
            errors++;
        end
        tick(1'b0);
        check_counters("redirect_counters");
    endtask

    task automatic test_halt();
        clear_inputs();
        mem_halt = 1'b1; ihit = 1'b1;
        #1;
        checks++;
        if (memwb_en !== 1'b1 || halt !== 1'b0) begin
            $display("FAIL halt_pre_edge: memwb_en=%b halt=%b expected 1 0", memwb_en, halt);
            errors++;
        end
        tick(1'b0);
        exp_halted = 1'b1;
        mem_ren = 1'b1; dhit = 1'b1;
        #1;
        checks++;
        if (halt !== 1'b1 || en !== 5'b00000 || fl !== 3'b000 || dmemREN !== 1'b0) begin
            $display("FAIL halt_entered: halt=%b en=%b fl=%b dmemREN=%b expected 1 00000 000 0",
                     halt, en, fl, dmemREN);
            errors++;
        end
        for (int i = 0; i < 5; i++) tick(1'b1);
        check_counters("halt_frozen");
        checks++;
        if (halt !== 1'b1) begin
            $display("FAIL halt_sticky: halt=%b expected 1", halt);
            errors++;
        end
    endtask

    task automatic test_reset_mid_access();
        clear_inputs();
        nRST = 1'b0;
        #1;
        exp_halted = 1'b0; exp_cyc = 0; exp_stl = 0;
        checks++;
        if (halt !== 1'b0) begin
            $display("FAIL halt_cleared: halt=%b expected 0", halt);
            errors++;
        end
        nRST = 1'b1;
        mem_wen = 1'b1; dhit = 1'b0;
        #1;
        checks++;
        if (dmemWEN !== 1'b1) begin
            $display("FAIL dmemWEN_active: dmemWEN=%b expected 1", dmemWEN);
            errors++;
        end
        tick(1'b1);
        tick(1'b1);
        check_counters("pre_reset_counters");
        nRST = 1'b0;
        #1;
        checks++;
        if (dmemWEN !== 1'b0 || cycle_count !== 32'd0 || stall_count !== 32'd0) begin
            $display("FAIL reset_mid_access: dmemWEN=%b cyc=%0d stl=%0d expected 0 0 0",
                     dmemWEN, cycle_count, stall_count);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_dmem_wait();
        test_redirect();
        test_halt();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
